ps2_line_editor: RTL and testbench

//  Parametrised PS/2 keyboard front end plus line editor, all in the clk_in domain.

---
 rtl/ps2_line_editor_if.sv | 26 ++
 rtl/ps2_line_editor.sv | 199 +++++++++++++++++++
 tb/tb_ps2_line_editor.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_line_editor_if.sv
// Completed-line handoff between the line editor and the instruction parser.
// The editor drives the line and its length; the parser answers with ready.
interface ps2_line_editor_if #(
   parameter int LINE_DEPTH = 32,
   parameter int CHAR_W     = 8,
   parameter int LEN_W      = $clog2(LINE_DEPTH + 1)
);
   logic                         line_valid_out;
   logic                         line_ready_in;
   logic [LEN_W-1:0]             line_len_out;
   logic [LINE_DEPTH*CHAR_W-1:0] line_out;

   modport master (
      output line_valid_out,
      output line_len_out,
      output line_out,
      input  line_ready_in
   );

   modport slave (
      input  line_valid_out,
      input  line_len_out,
      input  line_out,
      output line_ready_in
   );
endinterface

// File: rtl/ps2_line_editor.sv
// PS/2 keyboard deframer, scan-code to ASCII mapper and single-line editor.
// A finished line is held on line_if until the parser takes it.
module ps2_line_editor #(
   parameter int LINE_DEPTH  = 32,
   parameter int CHAR_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              ps2_clk_in,
   input  logic              ps2_data_in,
   output logic              key_pressed,
   output logic              bksp_pressed,
   output logic [CHAR_W-1:0] character,
   output logic              overflow_out,
   output logic              frame_err_out,
   ps2_line_editor_if.master line_if
);
   localparam int LEN_W = $clog2(LINE_DEPTH + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      IDLE, DATA, PARITY, STOP
   } state_t;

   state_t                       r_st, w_st_nxt;
   logic [SYNC_STAGES-1:0]       r_cs, r_ds;
   logic                         r_clk_d;
   logic [7:0]                   r_sr;
   logic                         r_par;
   logic [2:0]                   r_bitcnt;
   logic [TMO_W-1:0]             r_tmo;
   logic                         r_ext, r_brk, r_shift;
   logic                         r_valid;
   logic [LEN_W-1:0]             r_len;
   logic [LINE_DEPTH*CHAR_W-1:0] r_buf;

   logic       w_clk, w_dat, w_fall;
   logic       w_done, w_ferr, w_tmo;
   logic       w_live, w_accept;
   logic [6:0] w_ascii;

   function automatic logic [6:0] f_map(input logic [7:0] c,
                                        input logic sh);
      logic [6:0] a;
      a = '0;
      case (c)
         8'h1C: a = 7'h61; 8'h32: a = 7'h62; 8'h21: a = 7'h63;
         8'h23: a = 7'h64; 8'h24: a = 7'h65; 8'h2B: a = 7'h66;
         8'h34: a = 7'h67; 8'h33: a = 7'h68; 8'h43: a = 7'h69;
         8'h3B: a = 7'h6A; 8'h42: a = 7'h6B; 8'h4B: a = 7'h6C;
         8'h3A: a = 7'h6D; 8'h31: a = 7'h6E; 8'h44: a = 7'h6F;
         8'h4D: a = 7'h70; 8'h15: a = 7'h71; 8'h2D: a = 7'h72;
         8'h1B: a = 7'h73; 8'h2C: a = 7'h74; 8'h3C: a = 7'h75;
         8'h2A: a = 7'h76; 8'h1D: a = 7'h77; 8'h22: a = 7'h78;
         8'h35: a = 7'h79; 8'h1A: a = 7'h7A; 8'h29: a = 7'h20;
         8'h16: a = 7'h31; 8'h1E: a = 7'h32; 8'h26: a = 7'h33;
         8'h25: a = 7'h34; 8'h2E: a = 7'h35; 8'h36: a = 7'h36;
         8'h3D: a = 7'h37; 8'h3E: a = 7'h38; 8'h46: a = 7'h39;
         8'h45: a = 7'h30;
         default: a = '0;
      endcase
      if (sh && a >= 7'h61 && a <= 7'h7A) a = a - 7'h20;
      return a;
   endfunction

   assign w_clk    = r_cs[SYNC_STAGES-1];
   assign w_dat    = r_ds[SYNC_STAGES-1];
   assign w_fall   = r_clk_d & ~w_clk;
   assign w_tmo    = (r_st != IDLE) && !w_fall &&
                     (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
   assign w_ascii  = f_map(r_sr, r_shift);
   assign w_live   = !r_ext && !r_brk && !r_valid;
   assign w_accept = r_valid && line_if.line_ready_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) r_st <= IDLE;
      else        r_st <= w_st_nxt;
   end

   always_comb begin
      w_st_nxt = r_st;
      w_done   = 1'b0;
      w_ferr   = 1'b0;
      unique case (r_st)
         IDLE:   if (w_fall && !w_dat) w_st_nxt = DATA;
         DATA:   if (w_fall && r_bitcnt == 3'd7) w_st_nxt = PARITY;
         PARITY: if (w_fall) w_st_nxt = STOP;
         STOP: begin
            if (w_fall) begin
               w_st_nxt = IDLE;
               if (w_dat && (^{r_sr, r_par})) w_done = 1'b1;
               else                           w_ferr = 1'b1;
            end
         end
         default: w_st_nxt = IDLE;
      endcase
      if (w_tmo) begin
         w_st_nxt = IDLE;
         w_ferr   = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_cs     <= '1;
         r_ds     <= '1;
         r_clk_d  <= 1'b1;
         r_sr     <= '0;
         r_par    <= 1'b0;
         r_bitcnt <= '0;
         r_tmo    <= '0;
      end else begin
         r_cs    <= {r_cs[SYNC_STAGES-2:0], ps2_clk_in};
         r_ds    <= {r_ds[SYNC_STAGES-2:0], ps2_data_in};
         r_clk_d <= w_clk;
         if (r_st == IDLE || w_fall) r_tmo <= '0;
         else                        r_tmo <= r_tmo + 1'b1;
         if (w_fall) begin
            if (r_st == IDLE) r_bitcnt <= '0;
            if (r_st == DATA) begin
               r_sr     <= {w_dat, r_sr[7:1]};
               r_bitcnt <= r_bitcnt + 1'b1;
            end
            if (r_st == PARITY) r_par <= w_dat;
         end
      end
   end

   // Byte layer and editor: acts on the cycle the stop bit validates.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         key_pressed   <= 1'b0;
         bksp_pressed  <= 1'b0;
         character     <= '0;
         overflow_out  <= 1'b0;
         frame_err_out <= 1'b0;
         r_ext         <= 1'b0;
         r_brk         <= 1'b0;
         r_shift       <= 1'b0;
         r_valid       <= 1'b0;
         r_len         <= '0;
         r_buf         <= '0;
      end else begin
         key_pressed   <= 1'b0;
         bksp_pressed  <= 1'b0;
         character     <= '0;
         overflow_out  <= 1'b0;
         frame_err_out <= w_ferr;
         if (w_accept) begin
            r_valid <= 1'b0;
            r_len   <= '0;
            r_buf   <= '0;
         end
         if (w_done) begin
            unique case (1'b1)
               (r_sr == 8'hE0): r_ext <= 1'b1;
               (r_sr == 8'hF0): r_brk <= 1'b1;
               default: begin
                  r_ext <= 1'b0;
                  r_brk <= 1'b0;
                  if (!r_ext && (r_sr == 8'h12 || r_sr == 8'h59))
                     r_shift <= !r_brk;
                  if (w_live) begin
                     unique case (1'b1)
                        (w_ascii != 7'd0): begin
                           if (r_len < LEN_W'(LINE_DEPTH)) begin
                              r_buf[int'(r_len)*CHAR_W +: CHAR_W]
                                 <= CHAR_W'(w_ascii);
                              r_len       <= r_len + 1'b1;
                              key_pressed <= 1'b1;
                              character   <= CHAR_W'(w_ascii);
                           end else begin
                              overflow_out <= 1'b1;
                           end
                        end
                        (r_sr == 8'h66): begin
                           if (r_len != '0) begin
                              r_buf[(int'(r_len)-1)*CHAR_W +: CHAR_W]
                                 <= '0;
                              r_len        <= r_len - 1'b1;
                              bksp_pressed <= 1'b1;
                           end
                        end
                        (r_sr == 8'h5A): r_valid <= 1'b1;
                        default: ;
                     endcase
                  end
               end
            endcase
         end
      end
   end

   assign line_if.line_valid_out = r_valid;
   assign line_if.line_len_out   = r_len;
   assign line_if.line_out       = r_buf;
endmodule

// File: tb/tb_ps2_line_editor.sv
// Directed bench for ps2_line_editor: drives PS/2 frames and compares
// against a queue-based line model plus a few literal expectations.
module tb_ps2_line_editor;
   localparam int DEPTH = 32;
   localparam int TMO   = 300;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_dat = 1'b1;
   logic key_pressed, bksp_pressed, overflow_out, frame_err_out;
   logic [7:0] character;

   ps2_line_editor_if #(.LINE_DEPTH(DEPTH), .CHAR_W(8)) bus ();

   ps2_line_editor #(
      .LINE_DEPTH(DEPTH), .CHAR_W(8),
      .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_in(clk), .rst_in(rst),
      .ps2_clk_in(ps2_clk), .ps2_data_in(ps2_dat),
      .key_pressed(key_pressed), .bksp_pressed(bksp_pressed),
      .character(character), .overflow_out(overflow_out),
      .frame_err_out(frame_err_out), .line_if(bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   int p_key = 0, p_bk = 0, p_ovf = 0, p_ferr = 0;
   logic [7:0] p_char = '0;

   // Model state
   byte unsigned m_q[$];
   bit m_valid = 0, m_shift = 0, m_brk = 0, m_ext = 0;
   int e_key, e_bk, e_ovf, e_err;
   logic [7:0] e_char;

   byte unsigned letters[26] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   byte unsigned digits[10] = '{
      8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
      8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] m_vec();
      logic [255:0] v;
      v = '0;
      foreach (m_q[i]) v[i*8 +: 8] = m_q[i];
      return v;
   endfunction

   // -1 none, -2 enter, -3 backspace, else ASCII
   function automatic int m_lookup(input byte unsigned c, input bit sh);
      for (int i = 0; i < 26; i++)
         if (letters[i] == c) return (sh ? 65 : 97) + i;
      for (int i = 0; i < 10; i++)
         if (digits[i] == c) return (i == 9) ? 48 : 49 + i;
      if (c == 8'h29) return 32;
      if (c == 8'h5A) return -2;
      if (c == 8'h66) return -3;
      return -1;
   endfunction

   task automatic m_byte(input byte unsigned c);
      int a;
      if (c == 8'hE0) begin m_ext = 1; return; end
      if (c == 8'hF0) begin m_brk = 1; return; end
      if (!m_ext && (c == 8'h12 || c == 8'h59)) m_shift = !m_brk;
      if (!m_ext && !m_brk && !m_valid) begin
         a = m_lookup(c, m_shift);
         if (a >= 0) begin
            if (m_q.size() < DEPTH) begin
               m_q.push_back(8'(a));
               e_key = 1;
               e_char = 8'(a);
            end else e_ovf = 1;
         end else if (a == -3) begin
            if (m_q.size() > 0) begin
               void'(m_q.pop_back());
               e_bk = 1;
            end
         end else if (a == -2) m_valid = 1;
      end
      m_ext = 0;
      m_brk = 0;
   endtask

   always @(negedge clk) begin
      if (key_pressed) begin p_key++; p_char = character; end
      if (bksp_pressed) p_bk++;
      if (overflow_out) p_ovf++;
      if (frame_err_out) p_ferr++;
   end

   // Every quiet cycle the visible line must equal the model.
   always @(negedge clk) begin
      if (!key_pressed) chk("char_idle", character, 0);
      if (chk_en) begin
         chk("len", bus.line_len_out, m_q.size());
         chk("valid", bus.line_valid_out, m_valid);
         chk("line", bus.line_out, m_vec());
         chk("quiet_pulse",
             {key_pressed, bksp_pressed, overflow_out, frame_err_out}, 0);
      end
   end

   task automatic ps2_bit(input logic v);
      ps2_dat = v;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // mode 0: good, 1: bad parity, 2: abandon after 4 data bits
   task automatic frame(input logic [7:0] b, input int mode);
      int sk, sb, so, se, k;
      chk_en = 0;
      sk = p_key; sb = p_bk; so = p_ovf; se = p_ferr;
      e_key = 0; e_bk = 0; e_ovf = 0; e_err = 0; e_char = '0;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (mode == 2 && i == 4) break;
         ps2_bit(b[i]);
      end
      if (mode == 2) begin
         ps2_dat = 1'b1;
         k = 0;
         while (p_ferr == se && k < TMO + 100) begin
            @(negedge clk);
            k++;
         end
         repeat (3) @(negedge clk);
      end else begin
         ps2_bit(mode == 1 ? ^b : ~^b);
         ps2_bit(1'b1);
         repeat (6) @(negedge clk);
      end
      #1;
      if (mode != 0) e_err = 1;
      else m_byte(b);
      chk("key_cnt", p_key - sk, e_key);
      chk("bksp_cnt", p_bk - sb, e_bk);
      chk("ovf_cnt", p_ovf - so, e_ovf);
      chk("ferr_cnt", p_ferr - se, e_err);
      if (e_key != 0) chk("char", p_char, e_char);
      chk_en = 1;
   endtask

   task automatic accept();
      chk_en = 0;
      @(negedge clk);
      bus.line_ready_in = 1'b1;
      @(posedge clk);
      #1;
      bus.line_ready_in = 1'b0;
      m_valid = 0;
      m_q.delete();
      chk_en = 1;
      @(negedge clk);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int se;
      bus.line_ready_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outs", {key_pressed, bksp_pressed, character,
                       overflow_out, frame_err_out}, 0);
      chk("rst_line", {bus.line_valid_out, bus.line_len_out,
                       bus.line_out}, 0);
      rst = 1'b0;
      chk_en = 1;
      repeat (3) @(negedge clk);

      // make a, break a
      frame(8'h1C, 0); frame(8'hF0, 0); frame(8'h1C, 0);
      chk("t1_char", p_char, 8'h61);
      chk("t1_len", bus.line_len_out, 1);
      chk("t1_slot0", bus.line_out[7:0], 8'h61);

      // shifted A, release shift, b
      frame(8'h12, 0); frame(8'h1C, 0);
      chk("t2_A", p_char, 8'h41);
      frame(8'hF0, 0); frame(8'h12, 0); frame(8'h32, 0);
      chk("t2_b", p_char, 8'h62);
      frame(8'h5A, 0);
      accept();

      // backspace past empty
      frame(8'h1C, 0); frame(8'h32, 0);
      frame(8'h66, 0); frame(8'h66, 0); frame(8'h66, 0);
      chk("t4_len", bus.line_len_out, 0);
      chk("t4_bk", p_bk, 2);

      // fill and overflow
      for (int i = 0; i < 33; i++) frame(letters[i % 26], 0);
      chk("t3_len", bus.line_len_out, 32);
      chk("t3_ovf", p_ovf, 1);
      chk("t3_last", bus.line_out[255:248], 8'h66);
      frame(8'h5A, 0);
      accept();

      // held line, dropped key, then accept
      frame(8'h33, 0); frame(8'h43, 0); frame(8'h5A, 0);
      repeat (5) @(negedge clk);
      frame(8'h22, 0);
      chk("t5_valid", bus.line_valid_out, 1'b1);
      chk("t5_len", bus.line_len_out, 2);
      chk("t5_line", bus.line_out[15:0], 16'h6968);
      accept();
      chk("t5_clr", {bus.line_valid_out, bus.line_len_out}, 0);

      // ready with nothing pending is ignored
      bus.line_ready_in = 1'b1;
      repeat (3) @(negedge clk);
      bus.line_ready_in = 1'b0;

      // frame errors, then recovery
      frame(8'h1C, 1);
      frame(8'h1C, 2);
      frame(8'h1C, 0);
      chk("t6_recover", bus.line_out[7:0], 8'h61);

      // reset mid-frame aborts with no pulses
      chk_en = 0;
      se = p_ferr;
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_q.delete();
      m_valid = 0; m_shift = 0; m_brk = 0; m_ext = 0;
      repeat (TMO + 20) @(negedge clk);
      chk("rst_mid_err", p_ferr - se, 0);
      chk_en = 1;
      frame(8'h12, 0); frame(8'h29, 0); frame(8'h16, 0);
      chk("post_rst", bus.line_out[15:0], 16'h3120);

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end
endmodule
